// File: rtl/ex_stage.sv
// RV32I execute stage with the EX/MEM register: ALU, address/target generation, branch decision.
// Optional EX_MUL_EN: ALU op 15 returns the low 32 bits of rs1*B; otherwise op 15 returns 0.
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_imm_data,
  input  logic [XLEN-1:0] i_pc,
  input  logic [3:0]      i_alu_ctrl,
  input  logic [2:0]      i_func3,
  input  logic [6:0]      i_opcode,
  output logic [XLEN-1:0] o_result,
  output logic [XLEN-1:0] o_data_store,
  output logic            o_boj,
  output logic            o_jalr,
  output logic [XLEN-1:0] o_imm_data
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_EQ, ALU_NEQ, ALU_GE, ALU_GEU, ALU_BUF, ALU_MUL
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] data_store;
    logic            boj;
    logic            jalr;
    logic [XLEN-1:0] imm_data;
  } ex_mem_t;

  logic [XLEN-1:0] op_a, op_b, alu, rs1_imm;
  logic [4:0]      shamt;
  logic            br_taken;
  ex_mem_t         nxt, ex_mem_q;

  assign op_a    = (i_opcode == OP_AUIPC) ? i_pc : i_rs1_data;
  assign op_b    = (i_opcode == OP_R || i_opcode == OP_B) ? i_rs2_data : i_imm_data;
  assign shamt   = op_b[4:0];
  assign rs1_imm = i_rs1_data + i_imm_data;

  always_comb begin
    alu = '0;
    case (alu_op_e'(i_alu_ctrl))
      ALU_ADD:  alu = op_a + op_b;
      ALU_SUB:  alu = op_a - op_b;
      ALU_SLL:  alu = op_a << shamt;
      ALU_SLT:  alu = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu = {{(XLEN-1){1'b0}}, op_a < op_b};
      ALU_XOR:  alu = op_a ^ op_b;
      ALU_SRL:  alu = op_a >> shamt;
      ALU_SRA:  alu = $signed(op_a) >>> shamt;
      ALU_OR:   alu = op_a | op_b;
      ALU_AND:  alu = op_a & op_b;
      ALU_EQ:   alu = {{(XLEN-1){1'b0}}, op_a == op_b};
      ALU_NEQ:  alu = {{(XLEN-1){1'b0}}, op_a != op_b};
      ALU_GE:   alu = {{(XLEN-1){1'b0}}, $signed(op_a) >= $signed(op_b)};
      ALU_GEU:  alu = {{(XLEN-1){1'b0}}, op_a >= op_b};
      ALU_BUF:  alu = op_b;
`ifdef EX_MUL_EN
      ALU_MUL:  alu = i_rs1_data * op_b;
`else
      ALU_MUL:  alu = '0;
`endif
      default:  alu = '0;
    endcase
  end

  // Branch decision is independent of i_alu_ctrl so the decoder need not set it for B-type.
  always_comb begin
    br_taken = 1'b0;
    case (i_func3)
      3'b000:  br_taken = (i_rs1_data == i_rs2_data);
      3'b001:  br_taken = (i_rs1_data != i_rs2_data);
      3'b100:  br_taken = ($signed(i_rs1_data) <  $signed(i_rs2_data));
      3'b101:  br_taken = ($signed(i_rs1_data) >= $signed(i_rs2_data));
      3'b110:  br_taken = (i_rs1_data <  i_rs2_data);
      3'b111:  br_taken = (i_rs1_data >= i_rs2_data);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    nxt            = '0;
    nxt.result     = alu;
    nxt.data_store = i_rs2_data;
    nxt.imm_data   = i_imm_data;
    case (i_opcode)
      OP_LD, OP_S: nxt.result = rs1_imm;
      OP_B: begin
        nxt.result = i_pc + i_imm_data;
        nxt.boj    = br_taken;
      end
      OP_JAL: begin
        nxt.result = i_pc + 32'd4;
        nxt.boj    = 1'b1;
      end
      OP_JALR: begin
        nxt.result   = i_pc + 32'd4;
        nxt.boj      = 1'b1;
        nxt.jalr     = 1'b1;
        nxt.imm_data = {rs1_imm[XLEN-1:1], 1'b0};
      end
      default: ;  // R, I, LUI, AUIPC and unknown opcodes keep the ALU result
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_mem_q <= '0;
    else        ex_mem_q <= nxt;
  end

  assign o_result     = ex_mem_q.result;
  assign o_data_store = ex_mem_q.data_store;
  assign o_boj        = ex_mem_q.boj;
  assign o_jalr       = ex_mem_q.jalr;
  assign o_imm_data   = ex_mem_q.imm_data;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vectors, boundaries, mid-stream reset, random vs model.
module tb_ex_stage;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_UNK   = 7'b1111111;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] store;
    logic        boj;
    logic        jalr;
    logic [31:0] imm;
  } out_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] rs1 = '0, rs2 = '0, imm = '0, pc = '0;
  logic [3:0]  ctrl = '0;
  logic [2:0]  f3 = '0;
  logic [6:0]  op = OP_R;
  logic [31:0] o_result, o_data_store, o_imm_data;
  logic        o_boj, o_jalr;

  int n_checks = 0;
  int n_fail   = 0;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .i_rs1_data(rs1), .i_rs2_data(rs2), .i_imm_data(imm), .i_pc(pc),
    .i_alu_ctrl(ctrl), .i_func3(f3), .i_opcode(op),
    .o_result(o_result), .o_data_store(o_data_store), .o_boj(o_boj),
    .o_jalr(o_jalr), .o_imm_data(o_imm_data)
  );

  always #5 clk = ~clk;

  function automatic out_t act();
    return {o_result, o_data_store, o_boj, o_jalr, o_imm_data};
  endfunction

  // Reference: 64-bit arithmetic truncated, SRA built from a logical shift plus sign fill.
  function automatic out_t model(logic [31:0] r1, logic [31:0] r2, logic [31:0] im,
                                 logic [31:0] p, logic [3:0] c, logic [2:0] fn, logic [6:0] o);
    out_t e;
    longint unsigned a, b, s;
    logic [31:0] alu, a32, b32;
    int sh;
    a   = (o == OP_AUIPC) ? p : r1;
    b   = (o == OP_R || o == OP_B) ? r2 : im;
    a32 = a[31:0];
    b32 = b[31:0];
    sh  = b32 % 32;
    case (c)
      0:  s = a + b;
      1:  s = a + (64'h1_0000_0000 - b);
      2:  s = a << sh;
      3:  s = ($signed(a32) < $signed(b32)) ? 1 : 0;
      4:  s = (a < b) ? 1 : 0;
      5:  s = a ^ b;
      6:  s = a >> sh;
      7:  s = (a >> sh) | (a32[31] ? ~(64'hFFFF_FFFF >> sh) : 0);
      8:  s = a | b;
      9:  s = a & b;
      10: s = (a == b) ? 1 : 0;
      11: s = (a != b) ? 1 : 0;
      12: s = ($signed(a32) >= $signed(b32)) ? 1 : 0;
      13: s = (a >= b) ? 1 : 0;
      14: s = b;
`ifdef EX_MUL_EN
      default: s = longint'(r1) * b;
`else
      default: s = 0;
`endif
    endcase
    alu = s[31:0];
    e = '{result: alu, store: r2, boj: 1'b0, jalr: 1'b0, imm: im};
    if (o == OP_LD || o == OP_S) e.result = r1 + im;
    if (o == OP_B) begin
      e.result = p + im;
      case (fn)
        0: e.boj = (r1 == r2);
        1: e.boj = (r1 != r2);
        4: e.boj = ($signed(r1) < $signed(r2));
        5: e.boj = ($signed(r1) >= $signed(r2));
        6: e.boj = (r1 < r2);
        7: e.boj = (r1 >= r2);
        default: e.boj = 1'b0;
      endcase
    end
    if (o == OP_JAL || o == OP_JALR) begin
      e.result = p + 4;
      e.boj    = 1'b1;
    end
    if (o == OP_JALR) begin
      e.jalr = 1'b1;
      e.imm  = (r1 + im) & 32'hFFFF_FFFE;
    end
    return e;
  endfunction

  task automatic drive(logic [6:0] o, logic [3:0] c, logic [2:0] fn,
                       logic [31:0] r1, logic [31:0] r2, logic [31:0] im, logic [31:0] p);
    op = o; ctrl = c; f3 = fn; rs1 = r1; rs2 = r2; imm = im; pc = p;
  endtask

  task automatic test_reset();
    drive(OP_R, 4'd0, 3'd0, 32'h1111_1111, 32'h2222_2222, 32'h3, 32'h40);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (act() !== '0) begin
      n_fail++; $display("FAIL reset_state: got %h want 0", act());
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_directed();
    drive(OP_R, 4'd0, 3'd0, 32'hABCDE123, 32'h98765432, 32'h0, 32'h0);
    @(posedge clk); #1;
    n_checks++;
    if ({o_result, o_boj, o_jalr} !== {32'h44443555, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL r_add: got %h/%b/%b want 44443555/0/0", o_result, o_boj, o_jalr);
    end
    drive(OP_LD, 4'd14, 3'd2, 32'hABCDEFAB, 32'h5, 32'h8, 32'h0);
    @(posedge clk); #1;
    n_checks++;
    if ({o_result, o_imm_data} !== {32'hABCDEFB3, 32'h8}) begin
      n_fail++; $display("FAIL ld_addr: got %h/%h want ABCDEFB3/00000008", o_result, o_imm_data);
    end
    drive(OP_S, 4'd14, 3'd2, 32'h12345678, 32'h0, 32'h4, 32'h0);
    @(posedge clk); #1;
    n_checks++;
    if ({o_result, o_data_store} !== {32'h1234567C, 32'h0}) begin
      n_fail++; $display("FAIL st_addr: got %h/%h want 1234567C/00000000", o_result, o_data_store);
    end
    drive(OP_B, 4'd0, 3'b000, 32'hABCDEFAB, 32'hABCDEFAB, 32'h0, 32'h0);
    @(posedge clk); #1;
    n_checks++;
    if ({o_boj, o_result} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL beq_taken: got %b/%h want 1/00000000", o_boj, o_result);
    end
    rs2 = 32'h0;
    @(posedge clk); #1;
    n_checks++;
    if (o_boj !== 1'b0) begin
      n_fail++; $display("FAIL beq_not_taken: got %b want 0", o_boj);
    end
    drive(OP_JALR, 4'd0, 3'd0, 32'h201, 32'h0, 32'h4, 32'h100);
    @(posedge clk); #1;
    n_checks++;
    if ({o_result, o_boj, o_jalr, o_imm_data} !== {32'h104, 1'b1, 1'b1, 32'h204}) begin
      n_fail++; $display("FAIL jalr: got %h/%b/%b/%h want 00000104/1/1/00000204",
                         o_result, o_boj, o_jalr, o_imm_data);
    end
  endtask

  task automatic test_boundary();
    logic [31:0] want [5];
    logic [6:0]  ops  [5] = '{OP_I, OP_I, OP_I, OP_R, OP_UNK};
    logic [3:0]  ctl  [5] = '{4'd0, 4'd1, 4'd7, 4'd15, 4'd0};
    logic [31:0] a    [5] = '{32'hFFFFFFFF, 32'h0, 32'h80000000, 32'h10001, 32'h7};
    logic [31:0] b    [5] = '{32'h1, 32'h1, 32'd31, 32'h3, 32'h9};
    want = '{32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF,
`ifdef EX_MUL_EN
             32'h30003,
`else
             32'h0,
`endif
             32'h10};
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], ctl[i], 3'd0, a[i], b[i], b[i], 32'h0);
      @(posedge clk); #1;
      n_checks++;
      if ({o_result, o_boj, o_jalr} !== {want[i], 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL boundary_%0d: got %h/%b/%b want %h/0/0",
                           i, o_result, o_boj, o_jalr, want[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    out_t e;
    drive(OP_JALR, 4'd0, 3'd0, 32'h201, 32'h0, 32'h4, 32'h100);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (act() !== '0) begin
      n_fail++; $display("FAIL reset_async: got %h want 0", act());
    end
    drive(OP_R, 4'd5, 3'd0, 32'hF0F0_0F0F, 32'h0FF0_FF00, 32'h0, 32'h0);
    #2 rst_n = 1'b1;
    e = model(rs1, rs2, imm, pc, ctrl, f3, op);
    n_checks++;
    if (act() !== '0) begin
      n_fail++; $display("FAIL reset_release_hold: got %h want 0", act());
    end
    @(posedge clk); #1;
    n_checks++;
    if (act() !== e) begin
      n_fail++; $display("FAIL reset_first_load: got %h want %h", act(), e);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [10] = '{OP_R, OP_I, OP_LD, OP_S, OP_B, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_UNK};
    out_t e;
    for (int i = 0; i < 400; i++) begin
      drive(ops[$urandom_range(0, 9)], 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
            $urandom, $urandom, $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) rs2 = rs1;
      if ($urandom_range(0, 3) == 0) imm = rs2;
      e = model(rs1, rs2, imm, pc, ctrl, f3, op);
      @(posedge clk); #1;
      n_checks++;
      if (act() !== e) begin
        n_fail++; $display("FAIL random_%0d op=%b ctrl=%0d f3=%0d: got %h want %h",
                           i, op, ctrl, f3, act(), e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_boundary();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
